// File: rtl/etx_pkg.sv
// Shared definitions for the eLink TX burst sequencer: emesh field layout,
// burst-matching constants and the phase encoding that mirrors the I/O stage.
package etx_pkg;

    localparam int PKT_W        = 104;

    localparam int F_WRITE      = 0;
    localparam int F_DM_LSB     = 1;
    localparam int F_DM_W       = 2;
    localparam int F_CTRL_LSB   = 3;
    localparam int F_CTRL_W     = 4;
    localparam int F_DST_LSB    = 8;
    localparam int F_DST_W      = 32;
    localparam int F_DATA_LSB   = 40;
    localparam int F_DATA_W     = 32;
    localparam int F_SRC_LSB    = 72;
    localparam int F_SRC_W      = 32;

    localparam logic [F_DM_W-1:0]  DM_DOUBLE   = 2'b11;
    localparam logic [F_DST_W-1:0] BEAT_STRIDE = 32'd8;

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_C1   = 3'd1,
        PH_C2   = 3'd2,
        PH_C3   = 3'd3,
        PH_C4   = 3'd4,
        PH_C5   = 3'd5,
        PH_C6   = 3'd6,
        PH_C7   = 3'd7
    } phase_e;

endpackage

// File: rtl/etx_wait_sync.sv
// Two-flop synchronizer bringing an asynchronous pushback pin into tx_lclk.
module etx_wait_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/etx_burst_seq.sv
// Pops emesh packets from the TX FIFO and launches them aligned to the I/O
// serializer's 8-cycle frame, chaining contiguous double-word writes as bursts.
module etx_burst_seq
    import etx_pkg::*;
#(
    parameter int PW        = PKT_W,
    parameter int BURST_MAX = 16
) (
    input  logic          tx_lclk,
    input  logic          reset,
    input  logic          tx_enable,
    input  logic [PW-1:0] fifo_packet,
    input  logic          fifo_valid,
    output logic          fifo_read,
    input  logic          tx_wr_wait,
    input  logic          tx_rd_wait,
    output logic [PW-1:0] tx_packet,
    output logic          tx_access,
    output logic          tx_burst,
    output logic          tx_busy
);

    localparam int BW = $clog2(BURST_MAX + 1);

    phase_e          phase_q, phase_d;
    logic [BW-1:0]   beats_q, beats_d;
    logic            access_q, access_d;
    logic            burst_q, burst_d;
    logic [PW-1:0]   pkt_q, pkt_d;
    logic            pop;
    logic            wr_blk, rd_blk;
    logic            head_write, head_blocked;
    logic            launch_ok, cont_ok;

    etx_wait_sync u_wr_sync (
        .clk     (tx_lclk),
        .reset   (reset),
        .async_i (tx_wr_wait),
        .sync_o  (wr_blk)
    );

    etx_wait_sync u_rd_sync (
        .clk     (tx_lclk),
        .reset   (reset),
        .async_i (tx_rd_wait),
        .sync_o  (rd_blk)
    );

    assign head_write   = fifo_packet[F_WRITE];
    assign head_blocked = head_write ? wr_blk : rd_blk;
    assign launch_ok    = tx_enable & fifo_valid & ~head_blocked;

    // pkt_q doubles as the "last launched" packet for contiguity matching.
    assign cont_ok = tx_enable & fifo_valid & ~wr_blk
                   & head_write & pkt_q[F_WRITE]
                   & (fifo_packet[F_DM_LSB +: F_DM_W] == DM_DOUBLE)
                   & (pkt_q[F_DM_LSB +: F_DM_W] == DM_DOUBLE)
                   & (fifo_packet[F_CTRL_LSB +: F_CTRL_W] == pkt_q[F_CTRL_LSB +: F_CTRL_W])
                   & (fifo_packet[F_DST_LSB +: F_DST_W] == pkt_q[F_DST_LSB +: F_DST_W] + BEAT_STRIDE)
                   & (beats_q < BW'(BURST_MAX));

    always_comb begin
        phase_d  = phase_q;
        beats_d  = beats_q;
        access_d = 1'b0;
        burst_d  = 1'b0;
        pkt_d    = pkt_q;
        pop      = 1'b0;
        case (phase_q)
            PH_IDLE: begin
                // The launch cycle itself sits in IDLE; the frame counts from the next cycle.
                if (access_q) begin
                    phase_d = PH_C1;
                end else if (launch_ok) begin
                    pop      = 1'b1;
                    access_d = 1'b1;
                    pkt_d    = fifo_packet;
                    beats_d  = BW'(1);
                end
            end
            PH_C1: phase_d = PH_C2;
            PH_C2: phase_d = PH_C3;
            PH_C3: phase_d = PH_C4;
            PH_C4: phase_d = PH_C5;
            PH_C5: phase_d = PH_C6;
            PH_C6: begin
                phase_d = PH_C7;
                if (cont_ok) begin
                    pop      = 1'b1;
                    access_d = 1'b1;
                    burst_d  = 1'b1;
                    pkt_d    = fifo_packet;
                    beats_d  = beats_q + BW'(1);
                end
            end
            PH_C7:   phase_d = access_q ? PH_C4 : PH_IDLE;
            default: phase_d = PH_IDLE;
        endcase
    end

    always_ff @(posedge tx_lclk) begin
        if (reset) begin
            phase_q  <= PH_IDLE;
            beats_q  <= '0;
            access_q <= 1'b0;
            burst_q  <= 1'b0;
            pkt_q    <= '0;
        end else begin
            phase_q  <= phase_d;
            beats_q  <= beats_d;
            access_q <= access_d;
            burst_q  <= burst_d;
            pkt_q    <= pkt_d;
        end
    end

    assign fifo_read = pop & ~reset;
    assign tx_packet = pkt_q;
    assign tx_access = access_q;
    assign tx_burst  = burst_q;
    assign tx_busy   = (phase_q != PH_IDLE) | access_q;

endmodule

// File: tb/tb_etx_burst_seq.sv
// Bench for etx_burst_seq: a queue-backed FIFO feeds the DUT and every launch is
// compared with a frame-timing model derived from the sequencing rules.
module tb_etx_burst_seq;

    localparam int PW   = 104;
    localparam int BMAX = 16;
    localparam int LOGN = 4096;

    typedef struct {
        int          t;
        logic        b;
        logic [PW-1:0] p;
    } ev_t;

    logic          tx_lclk = 1'b0;
    logic          reset;
    logic          tx_enable;
    logic [PW-1:0] fifo_packet;
    logic          fifo_valid;
    logic          fifo_read;
    logic          tx_wr_wait;
    logic          tx_rd_wait;
    logic [PW-1:0] tx_packet;
    logic          tx_access;
    logic          tx_burst;
    logic          tx_busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [PW-1:0] fq[$];
    logic [PW-1:0] mq[$];
    ev_t           obs[$];
    ev_t           exp_q[$];
    bit            read_log [LOGN];
    bit            busy_log [LOGN];
    bit            zero_log [LOGN];

    etx_burst_seq #(.PW(PW), .BURST_MAX(BMAX)) dut (
        .tx_lclk     (tx_lclk),
        .reset       (reset),
        .tx_enable   (tx_enable),
        .fifo_packet (fifo_packet),
        .fifo_valid  (fifo_valid),
        .fifo_read   (fifo_read),
        .tx_wr_wait  (tx_wr_wait),
        .tx_rd_wait  (tx_rd_wait),
        .tx_packet   (tx_packet),
        .tx_access   (tx_access),
        .tx_burst    (tx_burst),
        .tx_busy     (tx_busy)
    );

    always #5 tx_lclk = ~tx_lclk;

    task automatic chk(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [PW-1:0] mk(input bit w, input logic [1:0] dm,
                                         input logic [3:0] ctrl, input logic [31:0] dst);
        logic [PW-1:0] p;
        p          = '0;
        p[0]       = w;
        p[2:1]     = dm;
        p[6:3]     = ctrl;
        p[39:8]    = dst;
        p[71:40]   = $urandom;
        p[103:72]  = $urandom;
        return p;
    endfunction

    function automatic bit chains(input logic [PW-1:0] last, input logic [PW-1:0] head);
        logic [31:0] want;
        want = last[39:8] + 32'd8;
        return last[0] && head[0] && (last[2:1] == 2'b11) && (head[2:1] == 2'b11)
            && (last[6:3] == head[6:3]) && (head[39:8] == want);
    endfunction

    // Frame start launches at pop+1; a continuation lands 7 cycles after a frame
    // start or 4 after a previous beat; a fresh frame needs 9 / 6 respectively.
    task automatic model_frames(input int s);
        int  a;
        int  beats;
        bit  start;
        a = s + 1; beats = 1; start = 1;
        exp_q.push_back('{a, 1'b0, mq[0]});
        for (int i = 1; i < mq.size(); i++) begin
            if (chains(mq[i-1], mq[i]) && beats < BMAX) begin
                a += start ? 7 : 4;
                start = 0;
                beats++;
                exp_q.push_back('{a, 1'b1, mq[i]});
            end else begin
                a += start ? 9 : 6;
                start = 1;
                beats = 1;
                exp_q.push_back('{a, 1'b0, mq[i]});
            end
        end
    endtask

    task automatic drive_fifo();
        fifo_valid  = (fq.size() != 0);
        fifo_packet = fifo_valid ? fq[0] : '0;
    endtask

    task automatic load();
        fq = mq;
        drive_fifo();
    endtask

    task automatic tick();
        bit rd;
        @(negedge tx_lclk);
        if (tx_access) obs.push_back('{cyc, tx_burst, tx_packet});
        if (cyc < LOGN) begin
            read_log[cyc] = fifo_read;
            busy_log[cyc] = tx_busy;
            zero_log[cyc] = (tx_packet == '0) && !tx_access && !tx_burst && !tx_busy;
        end
        chk("burst_needs_access", {127'b0, tx_burst & ~tx_access}, 128'd0);
        chk("read_needs_valid", {127'b0, fifo_read & ~fifo_valid}, 128'd0);
        rd = fifo_read;
        @(posedge tx_lclk);
        #1;
        if (rd && fq.size() != 0) void'(fq.pop_front());
        drive_fifo();
        cyc++;
    endtask

    function automatic int reads(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) if (i < LOGN && read_log[i]) n++;
        return n;
    endfunction

    task automatic check_events(input string tag);
        int n;
        chk($sformatf("%s count", tag), 128'(obs.size()), 128'(exp_q.size()));
        n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s[%0d] time", tag, i), 128'(obs[i].t), 128'(exp_q[i].t));
            chk($sformatf("%s[%0d] burst", tag, i), {127'b0, obs[i].b}, {127'b0, exp_q[i].b});
            chk($sformatf("%s[%0d] packet", tag, i), 128'(obs[i].p), 128'(exp_q[i].p));
        end
        obs.delete();
        exp_q.delete();
    endtask

    initial begin
        int s, d, e, n;
        logic [PW-1:0] p0, p1, p2, p3;
        logic [31:0]   dst;

        reset = 1'b1; tx_enable = 1'b0; tx_wr_wait = 1'b0; tx_rd_wait = 1'b0;
        fifo_valid = 1'b0; fifo_packet = '0;
        repeat (3) tick();
        chk("reset outputs zero", {127'b0, zero_log[2]}, 128'd1);
        chk("reset no pop", {127'b0, read_log[2]}, 128'd0);
        reset = 1'b0; tx_enable = 1'b1;
        repeat (3) tick();

        // single write
        s = cyc;
        mq = '{mk(1, 2'b11, 4'h0, 32'h1000)};
        load(); model_frames(s);
        repeat (14) tick();
        chk("single pop t0", {127'b0, read_log[s]}, 128'd1);
        chk("single busy t8", {127'b0, busy_log[s+8]}, 128'd1);
        chk("single idle t9", {127'b0, busy_log[s+9]}, 128'd0);
        check_events("single");

        // four contiguous double writes
        s = cyc;
        mq = '{mk(1, 2'b11, 4'h0, 32'h2000), mk(1, 2'b11, 4'h0, 32'h2008),
               mk(1, 2'b11, 4'h0, 32'h2010), mk(1, 2'b11, 4'h0, 32'h2018)};
        load(); model_frames(s);
        repeat (26) tick();
        chk("burst4 pops", 128'(reads(s, s + 25)), 128'd4);
        check_events("burst4");

        // non-contiguous pair
        s = cyc;
        mq = '{mk(1, 2'b11, 4'h0, 32'h3000), mk(1, 2'b11, 4'h0, 32'h3010)};
        load(); model_frames(s);
        repeat (22) tick();
        check_events("gap");

        // beat limit, with a 32-bit address wrap inside the chain
        s = cyc;
        mq.delete();
        dst = 32'hFFFF_FFC0;
        for (int i = 0; i < BMAX + 2; i++) begin
            mq.push_back(mk(1, 2'b11, 4'h5, dst));
            dst += 32'd8;
        end
        load(); model_frames(s);
        repeat (90) tick();
        check_events("beatmax");

        // reset in phase 4 of a burst
        s = cyc;
        p0 = mk(1, 2'b11, 4'h1, 32'h4000); p1 = mk(1, 2'b11, 4'h1, 32'h4008);
        p2 = mk(1, 2'b11, 4'h1, 32'h4010); p3 = mk(1, 2'b11, 4'h1, 32'h4018);
        mq = '{p0, p1, p2, p3};
        load();
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.push_back('{s + 1, 1'b0, p0});
        exp_q.push_back('{s + 8, 1'b1, p1});
        mq = '{p2, p3};
        model_frames(s + 10);
        repeat (22) tick();
        chk("reset cycle no pop", {127'b0, read_log[s+9]}, 128'd0);
        chk("after reset zero", {127'b0, zero_log[s+10]}, 128'd1);
        chk("after reset pop", {127'b0, read_log[s+10]}, 128'd1);
        check_events("reset");

        // write pushback
        tx_wr_wait = 1'b1;
        repeat (3) tick();
        s = cyc;
        mq = '{mk(1, 2'b11, 4'h0, 32'h5000)};
        load();
        repeat (10) tick();
        chk("wr_wait holds pop", 128'(reads(s, s + 9)), 128'd0);
        d = cyc;
        tx_wr_wait = 1'b0;
        model_frames(d + 2);
        repeat (14) tick();
        chk("wr release d+0", {127'b0, read_log[d]}, 128'd0);
        chk("wr release d+1", {127'b0, read_log[d+1]}, 128'd0);
        chk("wr release d+2", {127'b0, read_log[d+2]}, 128'd1);
        check_events("wrwait");

        // read ahead of a blocked write
        tx_wr_wait = 1'b1;
        repeat (3) tick();
        s = cyc;
        p0 = mk(0, 2'b10, 4'h2, 32'h5100);
        p1 = mk(1, 2'b11, 4'h2, 32'h5200);
        mq = '{p0, p1};
        load();
        mq = '{p0};
        model_frames(s);
        repeat (16) tick();
        d = cyc;
        tx_wr_wait = 1'b0;
        mq = '{p1};
        model_frames(d + 2);
        repeat (14) tick();
        check_events("rd_first");

        // enable drop mid-frame
        s = cyc;
        p0 = mk(1, 2'b11, 4'h3, 32'h6000); p1 = mk(1, 2'b11, 4'h3, 32'h6008);
        p2 = mk(1, 2'b11, 4'h3, 32'h6010);
        mq = '{p0, p1, p2};
        load();
        repeat (3) tick();
        tx_enable = 1'b0;
        exp_q.push_back('{s + 1, 1'b0, p0});
        repeat (17) tick();
        e = cyc;
        chk("disabled no pop", 128'(reads(s + 1, e - 1)), 128'd0);
        tx_enable = 1'b1;
        mq = '{p1, p2};
        model_frames(e);
        repeat (22) tick();
        check_events("enable");

        // randomized packet streams
        for (int k = 0; k < 6; k++) begin
            s = cyc;
            n = $urandom_range(3, 10);
            mq.delete();
            dst = (k == 0) ? 32'hFFFF_FFE8 : ($urandom & 32'hFFFF_FFF8);
            for (int i = 0; i < n; i++) begin
                int r;
                r = $urandom_range(0, 9);
                if ($urandom_range(0, 9) < 3) dst = $urandom & 32'hFFFF_FFF8;
                mq.push_back(mk(r != 0, (r < 8) ? 2'b11 : 2'($urandom_range(0, 3)),
                                (r == 9) ? 4'($urandom_range(0, 15)) : 4'h7, dst));
                dst += 32'd8;
            end
            load(); model_frames(s);
            repeat (n * 9 + 12) tick();
            check_events($sformatf("rand%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/etx_burst_seq.md
Name: etx_burst_seq

Overview:
- Transmit packet sequencer that sits directly upstream of the eLink TX I/O serializer, in the tx_lclk domain.
- Pops emesh packets from the TX FIFO and launches them with single-cycle tx_access pulses.
- Aligns its launches to the serializer's 8-cycle frame and 4-cycle burst-beat timing.
- Detects contiguous double-word writes and chains them as bursts via tx_burst, honouring the wr/rd pushback pins.

Parameters:
PW, 104, emesh packet width
BURST_MAX, 16, max beats chained in one frame (>=2)

Ports:
tx_lclk  in  1  fast I/O clock
reset  in  1  synchronous active-high reset
tx_enable  in  1  config enable; low = no new launches, the current frame completes
fifo_packet  in  PW  head-of-FIFO packet
fifo_valid  in  1  FIFO not empty
fifo_read  out  1  pop strobe; head is consumed in the same cycle
tx_wr_wait  in  1  async write pushback from pin
tx_rd_wait  in  1  async read pushback from pin
tx_packet  out  PW  registered packet to I/O stage
tx_access  out  1  one-cycle launch pulse
tx_burst  out  1  burst-continue flag, valid with tx_access in phase 7
tx_busy  out  1  frame in flight (phase!=0 or tx_access)

Behaviour:
- Clock and reset: tx_lclk; reset synchronous, active-high.
- On reset: all outputs 0, tx_packet 0, phase 0, beat count 0, wait synchronizers cleared. Reset mid-frame aborts immediately; no pop in the reset cycle.
- Packet fields (shared package): [0] write, [2:1] datamode, [6:3] ctrlmode, [39:8] dstaddr, [71:40] data, [103:72] srcaddr.
- Pushback: tx_wr_wait and tx_rd_wait pass through 2-flop synchronizers giving wr_blk and rd_blk.
- A packet is blocked if (write & wr_blk) | (~write & rd_blk).
- phase (3 bits) mirrors the I/O state: 0 = IDLE, 1..7 = CYCLE1..7.
- Phase 0: if tx_enable & fifo_valid & ~blocked(head):
  - fifo_read=1 this cycle.
  - Next cycle: tx_access=1, tx_burst=0, tx_packet=head, phase->1, beat count=1.
  - Last packet (dstaddr, ctrlmode) is captured for burst matching.
- Phases 1..5: advance by 1. fifo_read=0 and tx_access=0.
- Phase 6 is the burst decision. Eligible when all of the following hold:
  - tx_enable and fifo_valid
  - head write=1 and last write=1
  - head datamode=2'b11 and last datamode=2'b11
  - head ctrlmode == last ctrlmode
  - head dstaddr == last dstaddr + 8 (32-bit add, wrap allowed; 0xFFFFFFF8 -> 0x00000000 counts as contiguous)
  - ~wr_blk
  - beat count < BURST_MAX
- If eligible: fifo_read=1; next cycle (phase 7): tx_access=1, tx_burst=1, tx_packet=head, beat count +1, last updated; then phase->4.
- If not eligible: phase 7 with tx_access=0, tx_burst=0; then phase->0.
- Minimum gap: a new non-burst frame needs at least one phase-0 cycle after phase 7, so a back-to-back frame launch takes 9 cycles.
- tx_burst is never 1 unless tx_access is 1.
- tx_access is never asserted in phases 1..6.
- tx_enable falling mid-frame: no continuation; the frame ends after phase 7.
- Pushback rising mid-frame affects only the next launch/continuation decision.
- fifo_read is only asserted when fifo_valid=1.

Decomposition:
- Package etx_pkg holds:
  - field offsets/widths
  - the DM_DOUBLE=2'b11 constant
  - the phase encodings PH_IDLE..PH_C7
  - the beat-stride constant 8
- One sub-module: etx_wait_sync, a 2-flop synchronizer, instantiated twice.

Test Plan:
- Single write, dst 0x1000, fifo_valid 1 cycle -> fifo_read at t0, tx_access at t1, tx_burst never 1, phase returns to 0 at t9, tx_busy low at t9.
- Four writes dm=11, ctrl=0, dst 0x2000/2008/2010/2018 -> one launch plus 3 pulses with tx_burst=1, spaced 4 cycles apart (t1, t8, t12, t16), 4 pops total.
- Two writes dm=11 at dst 0x3000 and 0x3010 (non-contiguous) -> second packet is sent as a new frame, tx_access at t1 and t10, tx_burst=0.
- BURST_MAX=2 with 3 contiguous writes -> beats 1-2 are bursted; beat 3 gets tx_burst=0 and starts a new frame.
- tx_wr_wait=1 asserted before enqueueing a write -> no fifo_read while high. Deassert -> fifo_read within 3 cycles (2 sync + 1). A read packet queued first still launches if rd_wait=0.
- reset asserted at phase 4 of a burst -> next cycle all outputs 0 and phase 0, no pop. Release with fifo_valid=1 -> fresh launch with tx_burst=0.
